// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg: shared defaults and helpers for the scoreboarded register file.
//   XLEN_DEF / NREG_DEF / NRD_DEF / NWB_DEF / CNT_W_DEF : default parameter values
//   cnt_max(w) : largest value a w-bit pending counter may hold
package regfile_sb_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREG_DEF  = 32;
  localparam int unsigned NRD_DEF   = 2;
  localparam int unsigned NWB_DEF   = 2;
  localparam int unsigned CNT_W_DEF = 2;

  function automatic int unsigned cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/regfile_sb_pend_ctr.sv
// regfile_sb_pend_ctr: pending-write counter for one architectural register.
//   clk, rst     : clock, async active-high reset
//   inc_i        : accepted reservation of this register
//   dec_i        : number of write-back ports landing on this register
//   flush_i      : clear the counter (overrides inc/dec)
//   cnt_o        : current outstanding-write count
//   full_o       : counter at its maximum, no further reservation possible
//   underflow_o  : more write-backs than outstanding writes this cycle (comb)
module regfile_sb_pend_ctr
  import regfile_sb_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned DEC_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic [DEC_W-1:0] dec_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             full_o,
  output logic             underflow_o
);

  // One spare bit so cnt+inc and dec compare without wrapping.
  localparam int unsigned SW = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 1;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;
  logic [SW-1:0]    w_sum;
  logic [SW-1:0]    w_dec;

  assign w_sum       = SW'(r_cnt) + SW'(inc_i);
  assign w_dec       = SW'(dec_i);
  assign underflow_o = (w_dec > w_sum);
  assign full_o      = (r_cnt == CNT_W'(cnt_max(CNT_W)));
  assign cnt_o       = r_cnt;

  // inc is only granted when not full, so w_sum never exceeds the maximum.
  always_comb begin
    w_cnt_d = r_cnt;
    if (flush_i) begin
      w_cnt_d = '0;
    end else if (underflow_o) begin
      w_cnt_d = '0;
    end else begin
      w_cnt_d = CNT_W'(w_sum - w_dec);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with per-register pending-write scoreboard.
//   clk, rst              : clock, async active-high reset
//   rd_addr_i/rd_vld_i    : NRD combinational read ports (source operands)
//   rd_data_o/rd_busy_o   : bypassed read data, per-port unresolved hazard
//   stall_o               : any busy read port or a rejected reservation
//   rsv_i/rsv_addr_i      : reserve a destination register (writer issued)
//   rsv_rdy_o             : reservation can be accepted this cycle
//   wb_vld_i/addr/data    : NWB write-back ports
//   flush_i               : clear all pending counters, keep data
//   err_o                 : sticky write-back-without-reservation flag
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREG  = NREG_DEF,
  parameter int unsigned NRD   = NRD_DEF,
  parameter int unsigned NWB   = NWB_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  localparam int unsigned AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  input  logic [NRD-1:0]      rd_vld_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  output logic                stall_o,
  input  logic                rsv_i,
  input  logic [AW-1:0]       rsv_addr_i,
  output logic                rsv_rdy_o,
  input  logic [NWB-1:0]      wb_vld_i,
  input  logic [NWB*AW-1:0]   wb_addr_i,
  input  logic [NWB*XLEN-1:0] wb_data_i,
  input  logic                flush_i,
  output logic                err_o
);

  localparam int unsigned DW = $clog2(NWB + 1);

  logic [XLEN-1:0]  r_mem [1:NREG-1];
  logic             r_err;
  logic             r_flushed;

  logic [CNT_W-1:0] w_cnt [NREG];
  logic [DW-1:0]    w_dec [NREG];
  logic [NREG-1:0]  w_full;
  logic [NREG-1:0]  w_uflow;
  logic [NWB-1:0]   w_wb_eff;
  logic             w_rsv_acc;

  // After a flush, write-backs to idle registers belong to squashed instructions: drop them
  // entirely (no data write, no bypass, no decrement).
  always_comb begin
    w_wb_eff = '0;
    for (int unsigned w = 0; w < NWB; w++) begin
      w_wb_eff[w] = wb_vld_i[w] && (wb_addr_i[w*AW +: AW] != '0) &&
                    !(r_flushed && (w_cnt[wb_addr_i[w*AW +: AW]] == '0));
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      w_dec[r] = '0;
    end
    for (int unsigned w = 0; w < NWB; w++) begin
      if (w_wb_eff[w]) begin
        w_dec[wb_addr_i[w*AW +: AW]] = w_dec[wb_addr_i[w*AW +: AW]] + DW'(1);
      end
    end
  end

  // Ready looks at the registered count only; a same-cycle write-back does not free a slot.
  assign rsv_rdy_o = (rsv_addr_i == '0) || !w_full[rsv_addr_i];
  assign w_rsv_acc = rsv_i && rsv_rdy_o;

  assign w_cnt[0]   = '0;
  assign w_full[0]  = 1'b0;
  assign w_uflow[0] = 1'b0;

  for (genvar g = 1; g < NREG; g++) begin : g_ctr
    regfile_sb_pend_ctr #(
      .CNT_W (CNT_W),
      .DEC_W (DW)
    ) u_ctr (
      .clk         (clk),
      .rst         (rst),
      .inc_i       (w_rsv_acc && (rsv_addr_i == AW'(g))),
      .dec_i       (w_dec[g]),
      .flush_i     (flush_i),
      .cnt_o       (w_cnt[g]),
      .full_o      (w_full[g]),
      .underflow_o (w_uflow[g])
    );
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_rd;

    assign w_addr = rd_addr_i[p*AW +: AW];

    // Highest-index matching write-back port overrides the array value.
    always_comb begin
      w_rd = '0;
      if (w_addr != '0) begin
        w_rd = r_mem[w_addr];
        for (int unsigned w = 0; w < NWB; w++) begin
          if (w_wb_eff[w] && (wb_addr_i[w*AW +: AW] == w_addr)) begin
            w_rd = wb_data_i[w*XLEN +: XLEN];
          end
        end
      end
    end

    assign rd_data_o[p*XLEN +: XLEN] = w_rd;
    // Writes landing this cycle are bypassed, so only what remains outstanding is a hazard.
    assign rd_busy_o[p] = rd_vld_i[p] && (w_addr != '0) &&
                          (32'(w_cnt[w_addr]) > 32'(w_dec[w_addr]));
  end

  assign stall_o = (|rd_busy_o) || (rsv_i && !rsv_rdy_o);
  assign err_o   = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err     <= 1'b0;
      r_flushed <= 1'b0;
    end else begin
      if ((|w_uflow) && !flush_i && !r_flushed) begin
        r_err <= 1'b1;
      end
      if (flush_i) begin
        r_flushed <= 1'b1;
      end else if (w_rsv_acc) begin
        r_flushed <= 1'b0;
      end
    end
  end

  // Later ports are assigned last, so the highest index wins an address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 1; r < NREG; r++) begin
        r_mem[r] <= '0;
      end
    end else begin
      for (int unsigned w = 0; w < NWB; w++) begin
        if (w_wb_eff[w]) begin
          r_mem[wb_addr_i[w*AW +: AW]] <= wb_data_i[w*XLEN +: XLEN];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard bench for regfile_sb. A driver applies one cycle of stimulus,
// predicts the DUT outputs from a behavioural model and queues them; a monitor pops and
// compares on the falling edge.
module tb_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int NRD   = 2;
  localparam int NWB   = 2;
  localparam int CNT_W = 2;
  localparam int AW    = 5;
  localparam int CMAX  = 3;

  typedef struct packed {
    logic [NRD*XLEN-1:0] data;
    logic [NRD-1:0]      busy;
    logic                stall;
    logic                rdy;
    logic                err;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NRD*AW-1:0]   rd_addr_i = '0;
  logic [NRD-1:0]      rd_vld_i = '0;
  logic [NRD*XLEN-1:0] rd_data_o;
  logic [NRD-1:0]      rd_busy_o;
  logic                stall_o;
  logic                rsv_i = 1'b0;
  logic [AW-1:0]       rsv_addr_i = '0;
  logic                rsv_rdy_o;
  logic [NWB-1:0]      wb_vld_i = '0;
  logic [NWB*AW-1:0]   wb_addr_i = '0;
  logic [NWB*XLEN-1:0] wb_data_i = '0;
  logic                flush_i = 1'b0;
  logic                err_o;

  always #5 clk = ~clk;

  regfile_sb #(
    .XLEN  (XLEN),
    .NREG  (NREG),
    .NRD   (NRD),
    .NWB   (NWB),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr_i  (rd_addr_i),
    .rd_vld_i   (rd_vld_i),
    .rd_data_o  (rd_data_o),
    .rd_busy_o  (rd_busy_o),
    .stall_o    (stall_o),
    .rsv_i      (rsv_i),
    .rsv_addr_i (rsv_addr_i),
    .rsv_rdy_o  (rsv_rdy_o),
    .wb_vld_i   (wb_vld_i),
    .wb_addr_i  (wb_addr_i),
    .wb_data_i  (wb_data_i),
    .flush_i    (flush_i),
    .err_o      (err_o)
  );

  // Stimulus for the next cycle.
  int          s_ra [NRD];
  bit          s_rv [NRD];
  bit          s_rsv;
  int          s_rsv_a;
  bit          s_wv [NWB];
  int          s_wa [NWB];
  logic [31:0] s_wd [NWB];
  bit          s_flush;

  // Behavioural model: outstanding writes and contents per register.
  int          m_cnt [NREG];
  logic [31:0] m_mem [NREG];
  bit          m_err;
  bit          m_flushed;

  exp_t exp_q[$];
  exp_t m_e;
  int   nchk = 0;
  int   nerr = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      m_e = exp_q.pop_front();
      check("rd_data0", 64'(rd_data_o[31:0]), 64'(m_e.data[31:0]));
      check("rd_data1", 64'(rd_data_o[63:32]), 64'(m_e.data[63:32]));
      check("rd_busy", 64'(rd_busy_o), 64'(m_e.busy));
      check("stall", 64'(stall_o), 64'(m_e.stall));
      check("rsv_rdy", 64'(rsv_rdy_o), 64'(m_e.rdy));
      check("err", 64'(err_o), 64'(m_e.err));
    end
  end

  task automatic clear_stim();
    for (int i = 0; i < NRD; i++) begin
      s_ra[i] = 0;
      s_rv[i] = 0;
    end
    for (int i = 0; i < NWB; i++) begin
      s_wv[i] = 0;
      s_wa[i] = 0;
      s_wd[i] = '0;
    end
    s_rsv   = 0;
    s_rsv_a = 0;
    s_flush = 0;
  endtask

  task automatic drive_pins();
    for (int p = 0; p < NRD; p++) begin
      rd_addr_i[p*AW +: AW] = AW'(s_ra[p]);
      rd_vld_i[p]           = s_rv[p];
    end
    for (int w = 0; w < NWB; w++) begin
      wb_vld_i[w]               = s_wv[w];
      wb_addr_i[w*AW +: AW]     = AW'(s_wa[w]);
      wb_data_i[w*XLEN +: XLEN] = s_wd[w];
    end
    rsv_i      = s_rsv;
    rsv_addr_i = AW'(s_rsv_a);
    flush_i    = s_flush;
  endtask

  // Predict this cycle's outputs, queue them, then advance the model over the clock edge.
  task automatic predict_and_commit();
    int          dec [NREG];
    bit          eff [NWB];
    exp_t        e;
    logic [31:0] d;
    bit          acc;
    bit          uf;
    int          s;
    for (int r = 0; r < NREG; r++) dec[r] = 0;
    for (int w = 0; w < NWB; w++) begin
      eff[w] = s_wv[w] && (s_wa[w] != 0) && !(m_flushed && (m_cnt[s_wa[w]] == 0));
      if (eff[w]) dec[s_wa[w]]++;
    end
    e = '0;
    for (int p = 0; p < NRD; p++) begin
      d = 32'h0;
      if (s_ra[p] != 0) begin
        d = m_mem[s_ra[p]];
        for (int w = 0; w < NWB; w++) begin
          if (eff[w] && (s_wa[w] == s_ra[p])) d = s_wd[w];
        end
      end
      e.data[p*XLEN +: XLEN] = d;
      e.busy[p] = s_rv[p] && (s_ra[p] != 0) && (m_cnt[s_ra[p]] > dec[s_ra[p]]);
    end
    e.rdy   = (s_rsv_a == 0) || (m_cnt[s_rsv_a] != CMAX);
    e.stall = (|e.busy) || (s_rsv && !e.rdy);
    e.err   = m_err;
    exp_q.push_back(e);

    acc = s_rsv && e.rdy;
    uf  = 0;
    for (int r = 1; r < NREG; r++) begin
      if (s_flush) begin
        m_cnt[r] = 0;
      end else begin
        s = m_cnt[r] + ((acc && (s_rsv_a == r)) ? 1 : 0);
        if (dec[r] > s) begin
          uf       = 1;
          m_cnt[r] = 0;
        end else begin
          m_cnt[r] = s - dec[r];
        end
      end
    end
    for (int w = 0; w < NWB; w++) begin
      if (eff[w]) m_mem[s_wa[w]] = s_wd[w];
    end
    if (uf && !s_flush && !m_flushed) m_err = 1;
    if (s_flush) m_flushed = 1;
    else if (acc) m_flushed = 0;
  endtask

  task automatic apply();
    @(posedge clk);
    #1;
    drive_pins();
    predict_and_commit();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear_stim();
    drive_pins();
    for (int r = 0; r < NREG; r++) begin
      m_cnt[r] = 0;
      m_mem[r] = '0;
    end
    m_err     = 0;
    m_flushed = 0;
    // Expected outputs while held in reset; no model advance for this edge.
    m_e       = '0;
    m_e.rdy   = 1'b1;
    exp_q.push_back(m_e);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic rd(input int a0, input int a1);
    s_ra[0] = a0; s_rv[0] = 1;
    s_ra[1] = a1; s_rv[1] = 1;
  endtask

  task automatic rsv_only(input int a);
    clear_stim(); s_rsv = 1; s_rsv_a = a; apply();
  endtask

  initial begin
    clear_stim();
    do_reset();

    // Reset contents and x0 immutability.
    for (int i = 0; i < NREG / 2; i++) begin
      clear_stim(); rd(2 * i, 2 * i + 1); apply();
    end
    clear_stim(); s_wv[0] = 1; s_wa[0] = 0; s_wd[0] = 32'hDEADBEEF; rd(0, 0); apply();
    clear_stim(); rd(0, 1); apply();

    // Single pending write resolved by a same-cycle bypass.
    rsv_only(5);
    clear_stim(); rd(5, 0); apply();
    clear_stim(); rd(5, 5); s_wv[1] = 1; s_wa[1] = 5; s_wd[1] = 32'h1234; apply();
    clear_stim(); rd(5, 0); apply();

    // Counter saturation and drain.
    for (int i = 0; i < 4; i++) rsv_only(7);
    clear_stim(); rd(7, 7); apply();
    for (int i = 0; i < 3; i++) begin
      clear_stim(); rd(7, 0); s_wv[i % 2] = 1; s_wa[i % 2] = 7; s_wd[i % 2] = 32'h700 + i; apply();
    end
    clear_stim(); rd(7, 0); s_rsv = 1; s_rsv_a = 7; apply();
    clear_stim(); s_wv[0] = 1; s_wa[0] = 7; s_wd[0] = 32'h77; apply();

    // Two ports colliding on one register.
    rsv_only(9); rsv_only(9);
    clear_stim(); rd(9, 9); s_wv[0] = 1; s_wa[0] = 9; s_wd[0] = 32'hA;
    s_wv[1] = 1; s_wa[1] = 9; s_wd[1] = 32'hB; apply();
    clear_stim(); rd(9, 9); apply();

    // Reserve and write-back together.
    rsv_only(3);
    clear_stim(); rd(3, 0); s_rsv = 1; s_rsv_a = 3; s_wv[0] = 1; s_wa[0] = 3; s_wd[0] = 32'h33;
    apply();
    clear_stim(); rd(3, 3); apply();
    clear_stim(); s_wv[1] = 1; s_wa[1] = 3; s_wd[1] = 32'h34; apply();

    // Flush drops squashed write-backs; later underflow is sticky.
    rsv_only(4); rsv_only(4);
    clear_stim(); s_flush = 1; rd(4, 0); apply();
    clear_stim(); rd(4, 4); s_wv[0] = 1; s_wa[0] = 4; s_wd[0] = 32'h55; apply();
    clear_stim(); rd(4, 0); apply();
    rsv_only(1);
    clear_stim(); rd(6, 0); s_wv[0] = 1; s_wa[0] = 6; s_wd[0] = 32'h66; apply();
    for (int i = 0; i < 3; i++) begin
      clear_stim(); rd(6, 1); apply();
    end

    // Asynchronous reset in the middle of activity.
    rsv_only(2);
    do_reset();
    clear_stim(); rd(2, 6); s_rsv = 1; s_rsv_a = 2; apply();

    // Randomised phases, each starting from reset.
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      for (int n = 0; n < 500; n++) begin
        clear_stim();
        for (int p = 0; p < NRD; p++) begin
          s_ra[p] = int'($urandom_range(0, 7));
          s_rv[p] = $urandom_range(0, 3) != 0;
        end
        s_rsv   = $urandom_range(0, 1) == 1;
        s_rsv_a = int'($urandom_range(0, 7));
        for (int w = 0; w < NWB; w++) begin
          s_wv[w] = $urandom_range(0, 9) < 3;
          s_wa[w] = int'($urandom_range(0, 7));
          s_wd[w] = $urandom();
        end
        s_flush = $urandom_range(0, 49) == 0;
        apply();
      end
    end

    clear_stim();
    apply();
    repeat (3) @(posedge clk);
    nchk++;
    if (exp_q.size() != 0) begin
      nerr++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
